// File: rtl/t05_header_byte_packer_if.sv
// Bit-stream in / byte-stream out bundle for t05_header_byte_packer.
// The master side is the producer of header bits and the consumer of packed bytes.
interface t05_header_byte_packer_if;
  logic       bit_in;
  logic       bit_valid;
  logic       flush;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       done;
  logic       overflow;

  modport master (
    output bit_in, bit_valid, flush, byte_ready,
    input  byte_out, byte_valid, done, overflow
  );

  modport slave (
    input  bit_in, bit_valid, flush, byte_ready,
    output byte_out, byte_valid, done, overflow
  );
endinterface

// File: rtl/t05_header_byte_packer.sv
// Packs a serial header bit stream MSB-first into bytes and queues them in a small FIFO.
// Optional total-bit counter (o_bit_total) is built when T05_BIT_COUNT_EN is defined.
//
// state    | meaning
// ST_PACK  | accepting bits, pushing each completed byte
// ST_DRAIN | flush seen; waiting for the FIFO to empty, bits rejected
// ST_DONE  | one-cycle done pulse, bits accepted as in ST_PACK
module t05_header_byte_packer #(
  parameter int DEPTH = 4
`ifdef T05_BIT_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  t05_header_byte_packer_if.slave   io_bus
`ifdef T05_BIT_COUNT_EN
  , output logic [CNT_W-1:0]        o_bit_total
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_PACK, ST_DRAIN, ST_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_done;

  logic [7:0]  r_sreg;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0] r_count;
  logic        r_overflow;

  logic        w_accept;
  logic        w_flush_pk;
  logic [7:0]  w_sreg_shift;
  logic [2:0]  w_cnt_inc;
  logic        w_push;
  logic [7:0]  w_push_data;
  logic [7:0]  w_sreg_nxt;
  logic [2:0]  w_bit_cnt_nxt;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;
  logic        w_drop;
  logic        w_drain_bit;

  // Datapath: bit accept, byte completion and flush padding
  always_comb begin
    w_accept     = io_bus.bit_valid && (r_state != ST_DRAIN);
    w_flush_pk   = io_bus.flush && (r_state == ST_PACK);
    w_sreg_shift = w_accept ? {r_sreg[6:0], io_bus.bit_in} : r_sreg;
    w_cnt_inc    = w_accept ? (r_bit_cnt + 3'd1) : r_bit_cnt;
    // A completed byte wraps w_cnt_inc to 0, so a flush on that edge adds no pad byte
    w_push       = (w_accept && (r_bit_cnt == 3'd7)) ||
                   (w_flush_pk && (w_cnt_inc != 3'd0));
    w_push_data  = (w_cnt_inc == 3'd0) ? w_sreg_shift
                                       : (w_sreg_shift << (3'd0 - w_cnt_inc));
    w_bit_cnt_nxt = w_flush_pk ? 3'd0 : w_cnt_inc;
    w_sreg_nxt    = w_flush_pk ? 8'h00 : w_sreg_shift;
    w_drain_bit   = io_bus.bit_valid && (r_state == ST_DRAIN);
  end

  always_comb begin
    w_full = (r_count == DEPTH_C);
    w_pop  = (r_count != '0) && io_bus.byte_ready;
    // A pop frees the slot on the same edge, so a push into a full FIFO still lands
    w_wr   = w_push && (!w_full || w_pop);
    w_drop = w_push && w_full && !w_pop;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      ST_PACK:  if (io_bus.flush) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_count == '0) w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_PACK;
      end
      default:  w_state_nxt = ST_PACK;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_PACK;
      r_sreg     <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sreg     <= w_sreg_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_overflow <= r_overflow | w_drop | w_drain_bit;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr) r_mem[r_wptr] <= w_push_data;
  end

  assign io_bus.byte_valid = (r_count != '0);
  assign io_bus.byte_out   = (r_count != '0) ? r_mem[r_rptr] : 8'h00;
  assign io_bus.done       = w_done;
  assign io_bus.overflow   = r_overflow;

`ifdef T05_BIT_COUNT_EN
  logic [CNT_W-1:0] r_bit_total;

  // Saturating count of accepted bits; pad bits never pass through w_accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_total <= '0;
    end else if (w_accept && (r_bit_total != '1)) begin
      r_bit_total <= r_bit_total + 1'b1;
    end
  end

  assign o_bit_total = r_bit_total;
`else
  // Default build carries no bit counter.
`endif

endmodule

// File: tb/tb_t05_header_byte_packer.sv
// Scoreboard bench for t05_header_byte_packer: expected bytes are queued by stimulus, a negedge monitor checks pops.
module tb_t05_header_byte_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  t05_header_byte_packer_if bus ();
`ifdef T05_BIT_COUNT_EN
  logic [15:0] bit_total;
`endif

  t05_header_byte_packer dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
`ifdef T05_BIT_COUNT_EN
    , .o_bit_total (bit_total)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.byte_valid && bus.byte_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got %02h, expected no byte", bus.byte_out);
      end else begin
        check("byte_out", {24'h0, bus.byte_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic f);
    bus.bit_valid = v;
    bus.bit_in    = b;
    bus.flush     = f;
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) drive(1'b1, d[i], 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check(name, {31'h0, seen}, 32'd1);
    check({name, "_q_empty"}, exp_q.size(), 32'd0);
    @(posedge clk); #1;
    check({name, "_one_cycle"}, {31'h0, bus.done}, 32'd0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check(name, exp_q.size(), 32'd0);
    @(posedge clk); #1;
    check({name, "_empty"}, {31'h0, bus.byte_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat [5];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44; pat[4] = 8'h55;
    rst = 1'b1;
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.flush = 1'b0; bus.byte_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    check("rst_byte_valid", {31'h0, bus.byte_valid}, 32'd0);
    check("rst_byte_out",   {24'h0, bus.byte_out},   32'd0);
    check("rst_done",       {31'h0, bus.done},       32'd0);
    check("rst_overflow",   {31'h0, bus.overflow},   32'd0);
`ifdef T05_BIT_COUNT_EN
    check("rst_bit_total",  {16'h0, bit_total},      32'd0);
`endif

    // exact byte A5
    bus.byte_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    check("a5_valid", {31'h0, bus.byte_valid}, 32'd1);
    @(posedge clk); #1;
    check("a5_valid_gone", {31'h0, bus.byte_valid}, 32'd0);
    check("a5_q_empty", exp_q.size(), 32'd0);

    // header stream 1_0100_0001 + flush
    do_reset();
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h80);
    send_byte(8'hA0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    wait_done("hdr_done");
`ifdef T05_BIT_COUNT_EN
    check("hdr_bit_total", {16'h0, bit_total}, 32'd9);
`endif

    // empty flush: done two cycles after the flush cycle
    drive(1'b0, 1'b0, 1'b1);
    check("empty_done_c1", {31'h0, bus.done}, 32'd0);
    @(posedge clk); #1;
    check("empty_done_c2", {31'h0, bus.done}, 32'd1);
    @(posedge clk); #1;
    check("empty_done_c3", {31'h0, bus.done}, 32'd0);
`ifdef T05_BIT_COUNT_EN
    check("empty_bit_total", {16'h0, bit_total}, 32'd9);
`endif

    // backpressure: 5 bytes into a 4-deep FIFO
    bus.byte_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back(pat[k]);
      send_byte(pat[k]);
    end
    check("bp_overflow", {31'h0, bus.overflow},   32'd1);
    check("bp_valid",    {31'h0, bus.byte_valid}, 32'd1);
    check("bp_head",     {24'h0, bus.byte_out},   32'h11);
    @(posedge clk); #1;
    check("bp_head_held", {24'h0, bus.byte_out},  32'h11);
    bus.byte_ready = 1'b1;
    wait_drain("bp_drain");

    // 7 ones, then the 8th with flush: no pad byte
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    wait_done("sim_done");

    // reset mid-operation
    bus.byte_ready = 1'b0;
    send_byte(8'h5A);
    send_byte(8'hC3);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    check("mid_valid_before", {31'h0, bus.byte_valid}, 32'd1);
    do_reset();
    check("mid_valid",    {31'h0, bus.byte_valid}, 32'd0);
    check("mid_overflow", {31'h0, bus.overflow},   32'd0);
    check("mid_byte_out", {24'h0, bus.byte_out},   32'd0);
    bus.byte_ready = 1'b1;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    wait_drain("mid_fresh");

    // bit arriving in DRAIN is dropped and flags overflow
    bus.byte_ready = 1'b0;
    exp_q.push_back(8'h96);
    send_byte(8'h96);
    drive(1'b0, 1'b0, 1'b1);
    check("drain_no_ovf", {31'h0, bus.overflow}, 32'd0);
    drive(1'b1, 1'b1, 1'b0);
    check("drain_ovf", {31'h0, bus.overflow}, 32'd1);
    bus.byte_ready = 1'b1;
    wait_done("drain_done");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
